tmds_encoder: RTL and testbench
===============================

Name: tmds_encoder

Overview:
- Converts one 8-bit colour channel plus two control bits into 10-bit DVI TMDS symbols, one per pixel clock.
- Sits directly upstream of the per-lane 10-bit serialiser. Its 10-bit output feeds the serialiser's parallel input unchanged, bit 0 first on the wire.
- Three instances make one DVI link: blue carries hsync/vsync on ctrl, green and red carry ctrl=00.
- Implements DVI 1.0 transition minimisation with running-disparity DC balancing, as a 2-stage pipeline.

Parameters:
- None. Widths are fixed by the TMDS definition.

Ports:
- clk_pix  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low; clock clk_pix
- de  in  1  data enable: 1 = video data, 0 = control period
- d  in  8  pixel channel data, sampled when de=1
- ctrl  in  2  control bits {c1,c0}, sampled when de=0
- q  out  10  TMDS symbol to the serialiser

Behaviour:
- Reset values:
  - Every pipeline register and q go to 10'h354 (control token for ctrl=00).
  - The disparity counter cnt goes to 0.
  - Stage-1 de goes to 0.
- Latency: exactly 2 clk_pix cycles from the de/d/ctrl input to q. Throughput is 1 symbol per cycle, with no stalls and no handshake.
- Stage 1 (registered, sampled from de/d/ctrl):
  - Compute n1d = popcount(d).
  - use_xnor = (n1d > 4) or (n1d == 4 and d[0] == 0).
  - q_m[0] = d[0].
  - For i = 1..7: q_m[i] = q_m[i-1] XOR d[i], or XNOR when use_xnor.
  - q_m[8] = ~use_xnor.
  - Register q_m[8:0], n1 = popcount(q_m[7:0]) (4 bits), de and ctrl.
- Stage 2 (registered; produces q and the next cnt):
  - cnt is 5-bit two's complement. It holds even values only; |cnt| <= 10 is guaranteed by the algorithm. Arithmetic uses sign-extended 5-bit math. n0 = 8 - n1.
  - de=0 (control period):
    - ctrl 00 -> q = 10'b1101010100
    - ctrl 01 -> q = 10'b0010101011
    - ctrl 10 -> q = 10'b0101010100
    - ctrl 11 -> q = 10'b1010101011
    - cnt <= 0.
  - de=1, case A: cnt == 0 or n1 == n0.
    - q = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt <= cnt + (q_m[8] ? n1-n0 : n0-n1).
  - de=1, case B: (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1).
    - q = {1, q_m[8], ~q_m[7:0]}.
    - cnt <= cnt + 2*q_m[8] + (n0-n1).
  - de=1, case C: otherwise.
    - q = {0, q_m[8], q_m[7:0]}.
    - cnt <= cnt - 2*(~q_m[8]) + (n1-n0).
- Boundaries:
  - A de transition takes effect per symbol with no gap cycle.
  - The first data symbol after any control period always starts from cnt=0.
  - The cnt == 0 test takes priority over case B/C selection.
- Reset mid-operation: q immediately returns to 10'h354 and cnt returns to 0. In-flight symbols are discarded.
- No combinational path from any input to q.

Optional Feature:
- Macro: TMDS_DISP_MON_EN.
- When defined:
  - Adds output port disp [4:0], a direct copy of cnt.
  - Adds output port disp_err [0:0], sticky. It sets when cnt leaves -10..+10 or becomes odd, and clears only on rst_n.
  - Both reset to 0.
- When undefined: neither port exists and the logic is identical otherwise.

Test Plan:
- Reset held, then released with de=0, ctrl=00 -> q = 10'h354 during reset and continuously after.
- de=0 with ctrl stepping 00, 01, 10, 11 on consecutive cycles -> two cycles later q = 10'h354, 10'h0AB, 10'h154, 10'h2AB on consecutive cycles.
- After a control period, de=1 with d=8'h00 held -> q sequence 10'h100, 10'h3FF, 10'h100, 10'h3FF. cnt goes -8, +2, -6, +4. All values start 2 cycles after de rises.
- After a control period, single de=1 with d=8'hFF -> q = 10'h200 and cnt = -8. Then de=0 -> cnt = 0.
- Random d with random de bursts (10k cycles) against a reference model -> bit-exact q. Decoding each data symbol (undo bit 9 inversion, then XOR/XNOR chain per bit 8) returns the original d.
- With TMDS_DISP_MON_EN: the same random run gives disp_err = 0 throughout and disp always even and within ±10. Asserting rst_n mid-burst -> q = 10'h354 and disp = 0 immediately.

Source files
------------

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS encoder: 8-bit channel + 2 control bits -> 10-bit symbol, 2-stage pipeline.
// Define TMDS_DISP_MON_EN to add the disp/disp_err running-disparity monitor ports.
module tmds_encoder (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic       de,
  input  logic [7:0] d,
  input  logic [1:0] ctrl,
`ifdef TMDS_DISP_MON_EN
  output logic [4:0] disp,
  output logic       disp_err,
`endif
  output logic [9:0] q
);

  localparam logic [9:0] CtrlTok00 = 10'b1101010100;
  localparam logic [9:0] CtrlTok01 = 10'b0010101011;
  localparam logic [9:0] CtrlTok10 = 10'b0101010100;
  localparam logic [9:0] CtrlTok11 = 10'b1010101011;

  // Stage 1: transition-minimised q_m and its ones count.
  logic [3:0] w_n1d;
  logic       w_use_xnor;
  logic [8:0] w_qm;
  logic [3:0] w_n1qm;

  always_comb begin
    w_n1d = '0;
    for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'b000, d[i]};
    w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !d[0]);
    w_qm       = '0;
    w_qm[0]    = d[0];
    for (int i = 1; i < 8; i++) w_qm[i] = w_qm[i-1] ^ d[i] ^ w_use_xnor;
    w_qm[8] = ~w_use_xnor;
    w_n1qm  = '0;
    for (int i = 0; i < 8; i++) w_n1qm = w_n1qm + {3'b000, w_qm[i]};
  end

  logic [8:0] r_qm;
  logic [3:0] r_n1;
  logic       r_de;
  logic [1:0] r_ctrl;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_qm   <= '0;
      r_n1   <= '0;
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
    end else begin
      r_qm   <= w_qm;
      r_n1   <= w_n1qm;
      r_de   <= de;
      r_ctrl <= ctrl;
    end
  end

  // Stage 2: DC balancing. All cnt math is modulo-32 two's complement.
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_d;
  logic [9:0] w_q_d;
  logic [4:0] w_diff;
  logic       w_cnt_zero;
  logic       w_cnt_neg;
  logic       w_cnt_pos;

  // n1 - n0 == 2*n1 - 8
  assign w_diff     = {r_n1, 1'b0} - 5'd8;
  assign w_cnt_zero = (r_cnt == 5'd0);
  assign w_cnt_neg  = r_cnt[4];
  assign w_cnt_pos  = !r_cnt[4] && !w_cnt_zero;

  always_comb begin
    w_q_d   = CtrlTok00;
    w_cnt_d = r_cnt;
    if (!r_de) begin
      unique case (r_ctrl)
        2'b00:   w_q_d = CtrlTok00;
        2'b01:   w_q_d = CtrlTok01;
        2'b10:   w_q_d = CtrlTok10;
        2'b11:   w_q_d = CtrlTok11;
        default: w_q_d = CtrlTok00;
      endcase
      w_cnt_d = 5'd0;
    end else if (w_cnt_zero || (r_n1 == 4'd4)) begin
      w_q_d   = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_d = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if ((w_cnt_pos && (r_n1 > 4'd4)) || (w_cnt_neg && (r_n1 < 4'd4))) begin
      w_q_d   = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_d = r_cnt + {3'b000, r_qm[8], 1'b0} - w_diff;
    end else begin
      w_q_d   = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_d = r_cnt - {3'b000, ~r_qm[8], 1'b0} + w_diff;
    end
  end

  logic [9:0] r_q;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= CtrlTok00;
      r_cnt <= 5'd0;
    end else begin
      r_q   <= w_q_d;
      r_cnt <= w_cnt_d;
    end
  end

  assign q = r_q;

`ifdef TMDS_DISP_MON_EN
  logic r_disp_err;
  logic w_bad;

  assign w_bad = w_cnt_d[0] || ($signed(w_cnt_d) > 5'sd10) || ($signed(w_cnt_d) < -5'sd10);

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_err <= 1'b0;
    end else begin
      r_disp_err <= r_disp_err | w_bad;
    end
  end

  assign disp     = r_cnt;
  assign disp_err = r_disp_err;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: fixed vector table, reset corners and randomised bursts vs a model.
module tb_tmds_encoder;

  logic       clk_pix = 1'b0;
  logic       rst_n;
  logic       de;
  logic [7:0] d;
  logic [1:0] ctrl;
  logic [9:0] q;
`ifdef TMDS_DISP_MON_EN
  logic [4:0] disp;
  logic       disp_err;
`endif

  tmds_encoder dut (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .de       (de),
    .d        (d),
    .ctrl     (ctrl),
`ifdef TMDS_DISP_MON_EN
    .disp     (disp),
    .disp_err (disp_err),
`endif
    .q        (q)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic [9:0] q;
    int         cnt;
    logic       de;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic       de;
    logic [7:0] d;
    logic [1:0] ctrl;
    logic [9:0] q;
    int         cnt;
  } vec_t;

  exp_t exp_q[$];
  int   m_cnt;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[16];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d) at %0t", name, act, act, req, req,
               $time);
    end
  endtask

  // Reference: straight from the DVI encoding rules, plain integer arithmetic.
  task automatic model(input logic mde, input logic [7:0] md, input logic [1:0] mc,
                       output logic [9:0] mq);
    int         ones;
    int         n1;
    int         n0;
    bit         xn;
    logic [8:0] qm;
    if (!mde) begin
      case (mc)
        2'b00:   mq = 10'h354;
        2'b01:   mq = 10'h0AB;
        2'b10:   mq = 10'h154;
        default: mq = 10'h2AB;
      endcase
      m_cnt = 0;
    end else begin
      ones  = $countones(md);
      xn    = (ones > 4) || (ones == 4 && md[0] == 1'b0);
      qm[0] = md[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ md[i]) : (qm[i-1] ^ md[i]);
      qm[8] = ~xn;
      n1    = $countones(qm[7:0]);
      n0    = 8 - n1;
      if (m_cnt == 0 || n1 == n0) begin
        mq    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        m_cnt = m_cnt + (qm[8] ? n1 - n0 : n0 - n1);
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
        mq    = {1'b1, qm[8], ~qm[7:0]};
        m_cnt = m_cnt + 2 * int'(qm[8]) + (n0 - n1);
      end else begin
        mq    = {1'b0, qm[8], qm[7:0]};
        m_cnt = m_cnt - 2 * int'(!qm[8]) + (n1 - n0);
      end
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] b;
    logic [7:0] r;
    b    = s[9] ? ~s[7:0] : s[7:0];
    r[0] = b[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return r;
  endfunction

  // Drive one input symbol; the expected result comes from the table when given, else the model.
  task automatic drive(input logic nde, input logic [7:0] nd, input logic [1:0] nc,
                       input bit use_tbl, input logic [9:0] tq, input int tcnt);
    exp_t       e;
    logic [9:0] mq;
    de   = nde;
    d    = nd;
    ctrl = nc;
    model(nde, nd, nc, mq);
    e.q   = use_tbl ? tq : mq;
    e.cnt = use_tbl ? tcnt : m_cnt;
    e.de  = nde;
    e.d   = nd;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk_pix);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("q", int'(q), int'(e.q));
      if (e.de) check("decode", int'(decode(q)), int'(e.d));
`ifdef TMDS_DISP_MON_EN
      check("disp", int'($signed(disp)), e.cnt);
      check("disp_err", int'(disp_err), 0);
`endif
    end
  endtask

  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    de    = 1'b0;
    d     = 8'h00;
    ctrl  = 2'b00;
    #2;
    check("rst_q_now", int'(q), 'h354);
`ifdef TMDS_DISP_MON_EN
    check("rst_disp_now", int'(disp), 0);
    check("rst_disp_err", int'(disp_err), 0);
`endif
    repeat (2) @(posedge clk_pix);
    #1;
    check("rst_q_held", int'(q), 'h354);
    @(negedge clk_pix);
    rst_n = 1'b1;
    m_cnt = 0;
    exp_q.delete();
    e.q   = 10'h354;
    e.cnt = 0;
    e.de  = 1'b0;
    e.d   = 8'h00;
    exp_q.push_back(e);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    tbl[1]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    tbl[2]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    tbl[3]  = '{1'b0, 8'h00, 2'b01, 10'h0AB, 0};
    tbl[4]  = '{1'b0, 8'h00, 2'b10, 10'h154, 0};
    tbl[5]  = '{1'b0, 8'h00, 2'b11, 10'h2AB, 0};
    tbl[6]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    tbl[7]  = '{1'b1, 8'h00, 2'b00, 10'h100, -8};
    tbl[8]  = '{1'b1, 8'h00, 2'b00, 10'h3FF, 2};
    tbl[9]  = '{1'b1, 8'h00, 2'b00, 10'h100, -6};
    tbl[10] = '{1'b1, 8'h00, 2'b00, 10'h3FF, 4};
    tbl[11] = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    tbl[12] = '{1'b1, 8'hFF, 2'b00, 10'h200, -8};
    tbl[13] = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    // First data symbol after control must restart from cnt = 0.
    tbl[14] = '{1'b1, 8'h00, 2'b00, 10'h100, -8};
    tbl[15] = '{1'b0, 8'h00, 2'b00, 10'h354, 0};

    rst_n = 1'b1;
    de    = 1'b0;
    d     = 8'h00;
    ctrl  = 2'b00;
    #1;
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].de, tbl[i].d, tbl[i].ctrl, 1'b1, tbl[i].q, tbl[i].cnt);
      tick();
    end
    repeat (2) begin
      drive(1'b0, 8'h00, 2'b00, 1'b0, 10'h0, 0);
      tick();
    end

    for (int half = 0; half < 2; half++) begin
      int cycles = 0;
      while (cycles < 5000) begin
        int   len;
        logic bde;
        len = $urandom_range(1, 40);
        bde = ($urandom_range(0, 3) != 0);
        for (int j = 0; j < len; j++) begin
          drive(bde, 8'($urandom), 2'($urandom), 1'b0, 10'h0, 0);
          tick();
          cycles++;
        end
      end
      if (half == 0) begin
        for (int j = 0; j < 5; j++) begin
          drive(1'b1, 8'($urandom), 2'b00, 1'b0, 10'h0, 0);
          tick();
        end
        do_reset();
      end
    end

    repeat (2) begin
      drive(1'b0, 8'h00, 2'b00, 1'b0, 10'h0, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
